// File: rtl/hex_display_ctrl.sv
// Registered hex seven-segment controller: latches a value on load and drives
// active-low segments with per-digit decimal points, blinking and leading-zero blanking.
module hex_display_ctrl #(
  parameter int NDIGITS   = 6,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     load,
  input  logic [4*NDIGITS-1:0]     value,
  input  logic [NDIGITS-1:0]       dp_mask,
  input  logic [NDIGITS-1:0]       blink_mask,
  input  logic                     lz_blank,
  output logic [NDIGITS-1:0][7:0]  hex
);

  localparam int              CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(BLINK_DIV - 1);

  logic [4*NDIGITS-1:0]    value_q;
  logic [NDIGITS-1:0]      dp_q;
  logic [NDIGITS-1:0]      blink_q;
  logic [CW-1:0]           cnt;
  logic                    blink_phase;
  logic [NDIGITS-1:0]      lead_zero;
  logic [NDIGITS-1:0][7:0] hex_next;

  // Active-low segment pattern g..a for one hex nibble.
  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    logic zero_run;
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    zero_run  = 1'b1;
    lead_zero = '0;
    hex_next  = '1;
    // Scan from the most significant digit; digit 0 always shows something.
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (value_q[4*i +: 4] == 4'h0);
      lead_zero[i] = lz_blank && zero_run && (i != 0);
    end
    for (int i = 0; i < NDIGITS; i++) begin
      if (!enable || (blink_q[i] && !blink_phase))
        hex_next[i] = 8'hFF;
      else if (lead_zero[i])
        hex_next[i] = {~dp_q[i], 7'h7F};
      else
        hex_next[i] = {~dp_q[i], seg_code(value_q[4*i +: 4])};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q     <= '0;
      dp_q        <= '0;
      blink_q     <= '0;
      cnt         <= '0;
      blink_phase <= 1'b1;
      hex         <= '1;
    end else begin
      hex <= hex_next;
      // A load restarts the blink period visible, overriding a coincident wrap.
      if (load) begin
        value_q     <= value;
        dp_q        <= dp_mask;
        blink_q     <= blink_mask;
        cnt         <= '0;
        blink_phase <= 1'b1;
      end else if (cnt == CNT_MAX) begin
        cnt         <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Parametrised, registered hex seven-segment display controller for NDIGITS digits.
- Latches a display value on a load strobe and encodes each nibble to active-low segments.
- Supports per-digit decimal points, per-digit blinking from an internal divider, and optional leading-zero blanking.
- Sits between CPU/debug status registers and the board's seven-segment pins.

Parameters:
- NDIGITS, 6, number of digits; value width is 4*NDIGITS.
- BLINK_DIV, 25000000, clk cycles per blink half-period; must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  display enable; 0 blanks every digit
- load  in  1  single-cycle strobe; captures value, dp_mask and blink_mask
- value  in  4*NDIGITS  hex value; nibble i drives digit i, digit 0 = value[3:0]
- dp_mask  in  NDIGITS  bit i = 1 lights decimal point of digit i
- blink_mask  in  NDIGITS  bit i = 1 makes digit i blink
- lz_blank  in  1  leading-zero blanking enable (live, not latched)
- hex  out  [NDIGITS-1:0][7:0]  active-low segments; bit7 = dp, bits6:0 = g..a

Behaviour:
- Reset (async, rst high):
  - hex = all 8'hFF.
  - Latched value, dp and blink registers = 0.
  - Blink counter = 0; blink_phase = 1 (visible).
- Load:
  - On a clk edge with load = 1, value, dp_mask and blink_mask are copied into shadow registers.
  - With load = 0 the shadow registers hold.
- Outputs are registered. hex is recomputed every cycle from the shadow registers, enable, lz_blank and blink_phase.
  - A load sampled at edge k is visible on hex after edge k+1.
  - enable and lz_blank changes also take effect after one edge.
- Segment code for bits 6:0 (bit7 = ~dp):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:18, A:08, B:03, C:46, D:21, E:06, F:0E
- Per-digit priority, highest first:
  - enable = 0 -> 8'hFF.
  - Blink bit set and blink_phase = 0 -> 8'hFF, dp included.
  - Digit is a leading zero -> {~dp, 7'h7F}. The dp is still shown if its mask bit is set.
  - Otherwise -> {~dp, code(nibble)}.
- Leading zero definition:
  - lz_blank = 1, and the nibble and all higher nibbles are 0.
  - Digit 0 is never blanked: value 0 displays a single "0".
- Blink divider:
  - Counter width is clog2(BLINK_DIV). It increments every cycle.
  - At BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
  - The divider runs regardless of enable.
  - A load resets the counter to 0 and blink_phase to 1, so new data appears immediately. When a load coincides with a wrap, the load wins.
- Reset mid-operation: hex goes to 8'hFF immediately (asynchronous), and all state returns to reset values.
- No combinational path from inputs to hex.

Test Plan:
- Reset, then enable = 1, load value = 24'h0123AB, dp_mask = 6'b000100, blink_mask = 0, lz_blank = 0.
  - Required: two edges after load, hex[0] = 8'h83, hex[1] = 8'h88, hex[2] = 8'h30, hex[3] = 8'hA4, hex[4] = 8'hF9, hex[5] = 8'hC0.
  - Required: no change visible after the first edge.
- Same value with lz_blank = 1.
  - Required: hex[5] = 8'hFF; hex[4..0] unchanged.
  - Then load 0 -> hex[0] = 8'hC0, hex[5..1] = 8'hFF.
  - Then load 0 with dp_mask = 6'b000010 -> hex[1] = 8'h7F.
- BLINK_DIV = 4, load value = 6'h5 in digit 0, blink_mask = 6'b000001.
  - Required: hex[0] alternates 8'h92 / 8'hFF every 4 cycles.
  - Required: other digits remain steady.
- Load asserted on the cycle the blink counter reaches BLINK_DIV-1 during a blank phase.
  - Required: counter = 0, phase visible, new digit shown after the next edge, then 4 visible cycles.
- enable = 0 with loaded data -> all hex = 8'hFF after one edge. Re-enable -> prior data restored without a reload.
- Assert rst asynchronously mid-blink with data shown.
  - Required: hex = 8'hFF before the next clk edge.
  - After release with enable = 1 -> all digits show 8'hC0 (value 0, lz_blank = 0).
